// File: rtl/arb_defs.sv
`default_nettype none
// ============================================================================
// Module      : arb_defs (package)
// Description : Shared definitions for the memory arbiters: arbitration FSM
//               state encoding and the read-data value returned on errors.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_defs;

    // Arbitration FSM state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SREQ = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    // Read data returned with a timeout error (and on write completions)
    localparam int unsigned c_ERR_RDATA = 0;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way combinational round-robin pick. A lone requester
//               wins; on a conflict the requester that was not served last
//               wins.
// Ports       : req[1:0] - request vector
//               last     - index of the requester served last
//               valid    - at least one request present
//               sel      - index of the winning requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    assign valid = |req;
    // Conflict: alternate away from last; otherwise follow the lone request.
    assign sel   = (&req) ? ~last : req[1];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master / one-slave memory arbiter. Serialises requests
//               with one outstanding transaction, round-robin on conflict,
//               and a watchdog that turns a hung slave into an error
//               response.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               m0_*/m1_*             - master request / grant / response
//               s_*                   - registered slave request, slave
//                                       accept and completion
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import arb_defs::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,

    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_gnt,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam logic [7:0] c_WD_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic                r_owner;
    logic                r_last;
    logic [7:0]          r_wd;
    logic                r_s_req;
    logic                r_s_we;
    logic [ADDR_W-1:0]   r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic [DATA_W/8-1:0] r_s_wstrb;
    logic                r_m0_rvalid;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic                r_m0_err;
    logic                r_m1_rvalid;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_m1_err;

    logic                w_valid;
    logic                w_sel;
    logic                w_grant;
    logic                w_timeout;
    logic                w_to_resp;
    logic                w_resp_err;
    logic [DATA_W-1:0]   w_resp_data;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (r_last),
        .valid (w_valid),
        .sel   (w_sel)
    );

    assign w_grant = (r_state == c_IDLE) && w_valid;
    assign m0_gnt  = w_grant && !w_sel;
    assign m1_gnt  = w_grant &&  w_sel;

    // ">=" rather than "==": an accept in the timeout cycle moves to WAIT
    // with the counter already past the limit, so WAIT must expire at once.
    assign w_timeout = (r_wd >= c_WD_LIMIT);

    // Response selection; a completion in the timeout cycle beats the error.
    always_comb begin
        w_to_resp   = 1'b0;
        w_resp_err  = 1'b0;
        w_resp_data = DATA_W'(c_ERR_RDATA);
        case (r_state)
            c_SREQ: begin
                if (!s_gnt && w_timeout) begin
                    w_to_resp  = 1'b1;
                    w_resp_err = 1'b1;
                end
            end
            c_WAIT: begin
                if (s_rvalid) begin
                    w_to_resp = 1'b1;
                    if (!r_s_we) begin
                        w_resp_data = s_rdata;
                    end
                end else if (w_timeout) begin
                    w_to_resp  = 1'b1;
                    w_resp_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_wd        <= 8'd0;
            r_s_req     <= 1'b0;
            r_s_we      <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_err    <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses, zero otherwise.
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_err    <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_s_req   <= 1'b1;
                        r_s_we    <= w_sel ? m1_we    : m0_we;
                        r_s_addr  <= w_sel ? m1_addr  : m0_addr;
                        r_s_wdata <= w_sel ? m1_wdata : m0_wdata;
                        r_s_wstrb <= w_sel ? m1_wstrb : m0_wstrb;
                        r_owner   <= w_sel;
                        r_last    <= w_sel;
                        r_wd      <= 8'd0;
                        r_state   <= c_SREQ;
                    end
                end
                c_SREQ: begin
                    r_wd <= r_wd + 8'd1;
                    if (s_gnt) begin
                        r_s_req <= 1'b0;
                        r_state <= c_WAIT;
                    end else if (w_to_resp) begin
                        r_s_req <= 1'b0;
                        r_state <= c_RESP;
                    end
                end
                c_WAIT: begin
                    r_wd <= r_wd + 8'd1;
                    if (w_to_resp) begin
                        r_state <= c_RESP;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            if (w_to_resp) begin
                if (r_owner) begin
                    r_m1_rvalid <= 1'b1;
                    r_m1_rdata  <= w_resp_data;
                    r_m1_err    <= w_resp_err;
                end else begin
                    r_m0_rvalid <= 1'b1;
                    r_m0_rdata  <= w_resp_data;
                    r_m0_err    <= w_resp_err;
                end
            end
        end
    end

    assign s_req     = r_s_req;
    assign s_we      = r_s_we;
    assign s_addr    = r_s_addr;
    assign s_wdata   = r_s_wdata;
    assign s_wstrb   = r_s_wstrb;
    assign m0_rvalid = r_m0_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m0_err    = r_m0_err;
    assign m1_rvalid = r_m1_rvalid;
    assign m1_rdata  = r_m1_rdata;
    assign m1_err    = r_m1_err;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter that shares the SoC's single instruction/data memory port between the core's fetch master (m0) and the load/store master (m1). It serialises requests with one outstanding transaction, using round-robin on conflict. A watchdog converts a hung slave into an error response. It sits between the riscv core and the rom/ram slave inside soc.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 16, cycles from slave-request start to forced error; legal range 2..255
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- mN_req  in  1  master N request (N = 0, 1); held with fields stable until mN_gnt
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_wstrb  in  DATA_W/8  byte enables (writes only)
- mN_gnt  out  1  request captured this cycle; master may drop or change req next cycle
- mN_rvalid  out  1  one-cycle response pulse
- mN_rdata  out  DATA_W  read data, valid with rvalid; 0 on writes and errors
- mN_err  out  1  timeout error, valid with rvalid
- s_req  out  1  slave request, held until s_gnt
- s_we, s_addr, s_wdata, s_wstrb  out  as master  registered copy of the captured request
- s_gnt  in  1  slave accepted request
- s_rvalid  in  1  slave completion (read data or write ack)
- s_rdata  in  DATA_W  slave read data

## Operation
- States: IDLE, SREQ, WAIT, RESP. Registers: owner (1 bit), last (1 bit, last master served), req fields, rdata, err, wd counter (8 bits).
- IDLE: the pick is combinational. With one requester, that master wins. With both, the master != last wins. The winner's mN_gnt is 1 this cycle.
  - On a grant, capture the winner's fields into s_* and set owner = last = winner.
  - Clear wd, then go to SREQ. With no requests, stay in IDLE.
- SREQ: s_req = 1. If s_gnt = 1, go to WAIT.
- WAIT: if s_rvalid = 1, capture s_rdata (forced to 0 if we), set err = 0, and go to RESP.
- Watchdog: wd increments every cycle in SREQ and WAIT.
  - If wd == TIMEOUT-1 and no completion occurs that cycle, go to RESP with err = 1 and rdata = 0. s_req drops on leaving SREQ.
  - A completion (s_rvalid in WAIT) in the same cycle as the timeout wins; err = 0.
  - In SREQ, s_gnt in the timeout cycle counts as acceptance; the state moves to WAIT and wd keeps counting, so the next cycle times out.
- RESP: m[owner]_rvalid = 1 with rdata/err; the other master's rvalid = 0. Go to IDLE.
- s_rvalid and s_gnt are ignored outside WAIT and SREQ respectively. Late slave responses after a timeout are discarded.
- Masters never receive gnt outside IDLE. A request arriving during a transaction waits; round-robin guarantees service within one transaction.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, last = 1 (m0 wins the first conflict), wd = 0, all outputs 0.
- Reset mid-transaction abandons it: s_req drops immediately and no rvalid is issued.
- Best case, with req at cycle 0 and zero-wait slave:
  - mN_gnt at cycle 0, s_req at cycle 1, s_gnt at cycle 1.
  - WAIT at cycle 2 with s_rvalid at cycle 2.
  - mN_rvalid at cycle 3, next grant possible at cycle 4.
- Throughput is one transaction per 4 cycles minimum.
- Timeout: with s_req first high at cycle 1 and no slave activity, mN_rvalid/err appear at cycle TIMEOUT+1.
- Outputs s_*, mN_rvalid, mN_rdata and mN_err are register outputs. mN_gnt is combinational from state, mN_req and last.

## Structure
- Shared package/header arb_defs: state encoding (IDLE=2'd0, SREQ=2'd1, WAIT=2'd2, RESP=2'd3) and the error read-data constant (0).
- One sub-module, rr_pick2: inputs req[1:0] and last; outputs valid and sel. Pure combinational round-robin pick, reused by future arbiters.
- The watchdog and FSM stay in mem_arbiter.

## Test plan
- m0 read of 0x0000_0004, zero-wait slave returns 0x1234_5678 -> m0_gnt at cycle 0, m0_rvalid at cycle 3 with rdata 0x1234_5678, err = 0; m1 outputs stay 0.
- m0 and m1 both request continuously from reset -> grant order m0, m1, m0, m1; each rvalid goes only to the granted master.
- m1 write of 0xCAFE_F00D to 0x80 with wstrb 0xF -> s_we = 1, s_addr = 0x80, s_wdata and s_wstrb correct; m1_rvalid has rdata 0.
- Slave never asserts s_gnt, TIMEOUT = 16 -> s_req high for 16 cycles, then m0_rvalid with err = 1 and rdata 0. A late s_rvalid is ignored, and the next request succeeds.
- s_rvalid in the exact timeout cycle -> err = 0 and the real data is returned.
- rst pulled low while in WAIT -> all outputs 0 at once, no rvalid after release, and the first conflict goes to m0.
